vga_timing_gen: RTL
===================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the pixel clock and drives the physical VGA pins. Provides the scan coordinates (`vga_x`, `vga_y`, `video_on`) consumed by the sprite/overlay display blocks. Accepts their composited `rgb` back, then re-aligns sync and blanking to the display pipeline latency so pixels land on the correct screen position.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths in clocks
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths in lines
- `SYNC_POL`, 0, asserted sync level (0 = active-low)
- `PIPE_DLY`, 3, display-pipeline latency in clocks from `vga_x`/`vga_y` to a valid `rgb_in`; legal range 1..8

Ports:
- `vga_clk` in 1: pixel clock, 25.175 MHz nominal
- `sys_rst` in 1: synchronous, active-high reset
- `rgb_in` in 16: RGB565 pixel from the display pipeline
- `vga_x` out 10: current column; 0 outside the active area
- `vga_y` out 10: current row; 0 outside the active area
- `video_on` out 1: scan position is in the active area
- `line_start` out 1: one-clock pulse at `h_cnt == 0` on every line, including blank lines
- `frame_start` out 1: one-clock pulse at `h_cnt == 0`, `v_cnt == 0`
- `vga_hs`, `vga_vs` out 1: sync pins, latency-aligned
- `vga_de` out 1: latency-aligned data enable
- `vga_rgb` out 16: pin pixel data; 0 when `vga_de` is low

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = sum of the horizontal parameters (800).
  - `v_cnt` runs 0..V_TOTAL-1 (525) and increments when `h_cnt` wraps.
  - Both counters wrap to 0 together at the end of a frame.
- Region order within a line and within a frame: active, front porch, sync, back porch.
- Horizontal sync is asserted for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656, 752).
- Vertical sync is asserted for `v_cnt` in [490, 492), for whole lines.
- Stage-0 outputs (`vga_x`, `vga_y`, `video_on`, `line_start`, `frame_start`):
  - Registered decode of the current counters, updated every clock.
  - `video_on` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- Delay line: raw hs, vs and de pass through a PIPE_DLY-deep shift register, followed by one output register.
- Output register:
  - `vga_hs`, `vga_vs` and `vga_de` take the delay-line output.
  - `vga_rgb` takes `rgb_in` when the delayed de is 1, otherwise 0.
- Reset (`sys_rst` = 1 at an edge):
  - Counters and all stage-0 outputs become 0.
  - Every delay-line stage is cleared to the inactive state: de = 0, sync = !SYNC_POL.
  - `vga_de` = 0, `vga_rgb` = 0, `vga_hs` = `vga_vs` = !SYNC_POL.
- Reset asserted mid-frame has the same effect at that edge; no partial line is completed.

## Timing
- Stage-0 latency: at the first edge with `sys_rst` low, stage-0 loads the decode of (0,0).
  - `frame_start` = 1, `line_start` = 1, `video_on` = 1, `vga_x` = `vga_y` = 0.
  - The counter advances at the same edge.
- Pin latency: `vga_hs`, `vga_vs` and `vga_de` during cycle t+PIPE_DLY+1 reflect the stage-0 state of cycle t.
- Pixel alignment: `vga_rgb` during cycle t+PIPE_DLY+1 equals `rgb_in` during cycle t+PIPE_DLY, gated by the delayed de.
- Periods:
  - Line: exactly 800 clocks; `line_start` period is 800.
  - Frame: 420 000 clocks; `frame_start` period is 420 000.
- Active pixels per frame: 307 200 clocks with `vga_de` = 1.
- No handshake. `rgb_in` is sampled unconditionally every clock.

## Structure
- Package `vga_timing_pkg` holds:
  - the default 640x480 timing constants;
  - derived H_TOTAL, V_TOTAL, HS_START/HS_END and VS_START/VS_END;
  - the RGB565 width constant.
- One sub-module, `vga_sig_delay`: a parameterised width/depth shift register with a synchronous clear to a parameterised idle value. It is used for the {hs, vs, de} bundle.

## Test plan
- Reset values: hold `sys_rst` for 5 clocks, then release.
  - During reset: `vga_hs` = `vga_vs` = 1, `vga_de` = 0, `vga_rgb` = 0, stage-0 outputs all 0.
  - First edge after release: `frame_start` = 1.
- Horizontal sync: in line 0, `vga_hs` goes low exactly 660 clocks after `line_start` (656 + PIPE_DLY + 1) and stays low for 96 clocks.
- Vertical sync: `vga_vs` is low for exactly 1600 clocks per frame, starting 490×800 + 4 clocks after `frame_start`.
- Pixel alignment: drive `rgb_in` = {`vga_y`[5:0], `vga_x`} delayed by PIPE_DLY.
  - `vga_rgb` must match the expected pattern on every `vga_de` cycle; 307 200 matches per frame.
  - Repeat with PIPE_DLY = 1 and PIPE_DLY = 8.
- Blanking: drive `rgb_in` = 16'hFFFF constantly. `vga_rgb` = 0 whenever `vga_de` = 0, including porches and sync.
- Mid-frame reset: assert `sys_rst` at `v_cnt` = 200, `h_cnt` = 300 for 1 clock.
  - Next edge: `vga_de` = 0, `vga_hs` = 1.
  - After release: `frame_start` asserts, and the full frame period is 420 000 clocks thereafter.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and small helpers for the VGA raster generator.
package vga_timing_pkg;

    // Default 640x480@60 Hz timing, in pixel clocks (horizontal) and lines (vertical).
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // RGB565 pixel width and scan-counter width (covers totals up to 1023).
    localparam int unsigned RGB_W = 16;
    localparam int unsigned CNT_W = 10;

    // Bundle carried through the latency-alignment delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bus_t;

    // Pin level for a sync signal given whether it is asserted and the asserted polarity.
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// Fixed-depth shift register with synchronous clear to an idle value.
module vga_sig_delay #(
    parameter int unsigned      WIDTH    = 3,
    parameter int unsigned      DEPTH    = 3,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    // Shift by one stage per clock; stage 0 takes the new input.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers, cleared to the idle value on clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            stage_q <= {DEPTH{IDLE_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: scan counters, stage-0 coordinate decode, and
// latency-aligned sync/blanking/pixel output pins.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY = 3
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CNT_W-1:0] vga_x,
    output logic [CNT_W-1:0] vga_y,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [RGB_W-1:0] vga_rgb
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic      SYNC_IDLE = ~SYNC_POL;
    localparam sync_bus_t BUS_IDLE  = '{hs: SYNC_IDLE, vs: SYNC_IDLE, de: 1'b0};

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    logic [CNT_W-1:0] vga_x_q, vga_x_d;
    logic [CNT_W-1:0] vga_y_q, vga_y_d;
    logic             video_on_q, video_on_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             hs_raw_q, hs_raw_d;
    logic             vs_raw_q, vs_raw_d;

    sync_bus_t        bus_in;
    sync_bus_t        bus_dly;

    logic             vga_hs_q, vga_hs_d;
    logic             vga_vs_q, vga_vs_d;
    logic             vga_de_q, vga_de_d;
    logic [RGB_W-1:0] vga_rgb_q, vga_rgb_d;

    // Next counter values: h wraps every line, v steps on the h wrap and wraps per frame.
    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + CNT_W'(1);
            end
        end
    end

    // Stage-0 decode of the current counter position.
    always_comb begin
        video_on_d    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        vga_x_d       = video_on_d ? h_cnt_q : '0;
        vga_y_d       = video_on_d ? v_cnt_q : '0;
        line_start_d  = (h_cnt_q == '0);
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        hs_raw_d      = sync_level((h_cnt_q >= HS_START) && (h_cnt_q < HS_END), SYNC_POL);
        vs_raw_d      = sync_level((v_cnt_q >= VS_START) && (v_cnt_q < VS_END), SYNC_POL);
    end

    // Counters and stage-0 registers; reset restarts the raster at (0,0).
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hs_raw_q      <= SYNC_IDLE;
            vs_raw_q      <= SYNC_IDLE;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hs_raw_q      <= hs_raw_d;
            vs_raw_q      <= vs_raw_d;
        end
    end

    // Delay the stage-0 sync/blanking bundle by the display-pipeline latency.
    assign bus_in = '{hs: hs_raw_q, vs: vs_raw_q, de: video_on_q};

    vga_sig_delay #(
        .WIDTH    ($bits(sync_bus_t)),
        .DEPTH    (PIPE_DLY),
        .IDLE_VAL (BUS_IDLE)
    ) u_sync_dly (
        .clk  (vga_clk),
        .clr  (sys_rst),
        .din  (bus_in),
        .dout (bus_dly)
    );

    // Pin values: delayed sync/de, pixel gated so blanking always drives black.
    always_comb begin
        vga_hs_d  = bus_dly.hs;
        vga_vs_d  = bus_dly.vs;
        vga_de_d  = bus_dly.de;
        vga_rgb_d = bus_dly.de ? rgb_in : '0;
    end

    // Output pin registers.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            vga_hs_q  <= SYNC_IDLE;
            vga_vs_q  <= SYNC_IDLE;
            vga_de_q  <= 1'b0;
            vga_rgb_q <= '0;
        end else begin
            vga_hs_q  <= vga_hs_d;
            vga_vs_q  <= vga_vs_d;
            vga_de_q  <= vga_de_d;
            vga_rgb_q <= vga_rgb_d;
        end
    end

    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_de      = vga_de_q;
    assign vga_rgb     = vga_rgb_q;

endmodule
